// File: rtl/campfire_checkpoint_ctrl_pkg.sv
// Shared game definitions for the campfire checkpoint: FSM encoding,
// campfireState word layout and the AABB overlap helper.
package campfire_checkpoint_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_UNLIT    = 2'd0,
    ST_LIGHTING = 2'd1,
    ST_LIT      = 2'd2,
    ST_RESPAWN  = 2'd3
  } camp_state_e;

  // campfireState field offsets and widths (MSB first in the packed word)
  localparam int CS_X_LSB        = 22;
  localparam int CS_X_W          = 10;
  localparam int CS_Y_LSB        = 12;
  localparam int CS_Y_W          = 10;
  localparam int CS_LIT_BIT      = 11;
  localparam int CS_LIGHTING_BIT = 10;
  localparam int CS_FRAME_LSB    = 8;
  localparam int CS_FRAME_W      = 2;
  localparam int CS_PROG_LSB     = 0;
  localparam int CS_PROG_W       = 8;

  typedef struct packed {
    logic [CS_X_W-1:0]     x;
    logic [CS_Y_W-1:0]     y;
    logic                  lit;
    logic                  lighting;
    logic [CS_FRAME_W-1:0] frame;
    logic [CS_PROG_W-1:0]  progress;
  } camp_word_t;

  // Strict AABB overlap in 11-bit arithmetic so right/bottom edges never wrap.
  // Boxes that only share an edge do not overlap.
  function automatic logic aabb_overlap(
    input logic [9:0]  ax, ay,
    input logic [10:0] aw, ah,
    input logic [9:0]  bx, by,
    input logic [10:0] bw, bh
  );
    logic [10:0] ax0, ay0, bx0, by0;
    ax0 = {1'b0, ax};
    ay0 = {1'b0, ay};
    bx0 = {1'b0, bx};
    by0 = {1'b0, by};
    return (ax0 < bx0 + bw) && (ax0 + aw > bx0) &&
           (ay0 < by0 + bh) && (ay0 + ah > by0);
  endfunction

endpackage

// File: rtl/campfire_checkpoint_ctrl_flame_anim_counter.sv
// Flame animation: advances the frame every FRAME_TICKS ticks while enabled,
// parks at frame 0 otherwise.
module flame_anim_counter
  import campfire_checkpoint_ctrl_pkg::*;
#(
  parameter int FRAME_TICKS = 8,
  parameter int NUM_FRAMES  = 4
) (
  input  logic                  sim_clk,
  input  logic                  reset,
  input  logic                  en_i,
  output logic [CS_FRAME_W-1:0] frame_o
);

  localparam int CNT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(FRAME_TICKS - 1);
  localparam logic [CS_FRAME_W-1:0] FRAME_LAST = CS_FRAME_W'(NUM_FRAMES - 1);

  logic [CNT_W-1:0]      frame_cnt_q;
  logic [CS_FRAME_W-1:0] frame_q;

  // Tick counter and frame index; both cleared whenever the flame is not lit
  always_ff @(posedge sim_clk) begin
    if (reset || !en_i) begin
      frame_cnt_q <= '0;
      frame_q     <= '0;
    end else if (frame_cnt_q == CNT_LAST) begin
      frame_cnt_q <= '0;
      frame_q     <= (frame_q == FRAME_LAST) ? '0 : frame_q + 1'b1;
    end else begin
      frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  assign frame_o = frame_q;

endmodule

// File: rtl/campfire_checkpoint_ctrl.sv
// Campfire checkpoint controller: lighting sequence while the player holds
// interact over the campfire, respawn request/ack after a death, flame
// animation and the packed campfireState word for the renderer.
module campfire_checkpoint_ctrl
  import campfire_checkpoint_ctrl_pkg::*;
#(
  parameter logic [9:0] CAMP_X      = 10'd250,
  parameter logic [9:0] CAMP_Y      = 10'd180,
  parameter int         CAMP_W      = 16,
  parameter int         CAMP_H      = 16,
  parameter int         PLAYER_W    = 16,
  parameter int         PLAYER_H    = 16,
  parameter logic [9:0] SPAWN_X     = 10'd20,
  parameter logic [9:0] SPAWN_Y     = 10'd200,
  parameter int         LIGHT_TICKS = 30,
  parameter int         FRAME_TICKS = 8,
  parameter int         NUM_FRAMES  = 4
) (
  input  logic        sim_clk,
  input  logic        reset,
  input  logic [9:0]  player_x,
  input  logic [9:0]  player_y,
  input  logic        interact,
  input  logic        player_dead,
  input  logic        respawn_ack,
  output logic        respawn_req,
  output logic [9:0]  respawn_x,
  output logic [9:0]  respawn_y,
  output logic        checkpoint_set,
  output logic [31:0] campfireState
);

  // Respawn spot once lit: standing on top of the campfire
  localparam logic [9:0]           LIT_RESPAWN_Y = 10'(CAMP_Y - PLAYER_H);
  localparam logic [CS_PROG_W-1:0] PROG_LAST     = CS_PROG_W'(LIGHT_TICKS - 1);
  localparam logic [CS_PROG_W-1:0] PROG_FULL     = CS_PROG_W'(LIGHT_TICKS);

  camp_state_e           state_q;
  logic [CS_PROG_W-1:0]  progress_q;
  logic                  lit_q;
  logic                  req_q;
  logic                  cp_set_q;
  logic [9:0]            rx_q, ry_q;
  logic [CS_FRAME_W-1:0] frame;
  camp_word_t            cs_q;

  logic overlap;
  logic light_cond;

  assign overlap = aabb_overlap(player_x, player_y, 11'(PLAYER_W), 11'(PLAYER_H),
                                CAMP_X, CAMP_Y, 11'(CAMP_W), 11'(CAMP_H));
  assign light_cond = overlap && interact;

  // Checkpoint FSM: lighting progress, lit flag, respawn handshake and position.
  // A death outside RESPAWN wins over everything else in the same tick.
  always_ff @(posedge sim_clk) begin
    if (reset) begin
      state_q    <= ST_UNLIT;
      progress_q <= '0;
      lit_q      <= 1'b0;
      req_q      <= 1'b0;
      cp_set_q   <= 1'b0;
      rx_q       <= SPAWN_X;
      ry_q       <= SPAWN_Y;
    end else begin
      cp_set_q <= 1'b0;
      if (player_dead && state_q != ST_RESPAWN) begin
        state_q    <= ST_RESPAWN;
        req_q      <= 1'b1;
        progress_q <= '0;
        rx_q       <= lit_q ? CAMP_X : SPAWN_X;
        ry_q       <= lit_q ? LIT_RESPAWN_Y : SPAWN_Y;
      end else begin
        case (state_q)
          ST_UNLIT: begin
            if (light_cond) begin
              if (LIGHT_TICKS == 1) begin
                state_q    <= ST_LIT;
                lit_q      <= 1'b1;
                cp_set_q   <= 1'b1;
                progress_q <= PROG_FULL;
              end else begin
                state_q    <= ST_LIGHTING;
                progress_q <= 8'd1;
              end
            end
          end
          ST_LIGHTING: begin
            if (!light_cond) begin
              // Releasing or stepping away forfeits all progress
              state_q    <= ST_UNLIT;
              progress_q <= '0;
            end else if (progress_q == PROG_LAST) begin
              state_q    <= ST_LIT;
              lit_q      <= 1'b1;
              cp_set_q   <= 1'b1;
              progress_q <= PROG_FULL;
            end else begin
              progress_q <= progress_q + 1'b1;
            end
          end
          ST_LIT: begin
            // Lit until reset; interact has no further effect
          end
          ST_RESPAWN: begin
            if (respawn_ack) begin
              req_q   <= 1'b0;
              state_q <= lit_q ? ST_LIT : ST_UNLIT;
            end
          end
          default: state_q <= ST_UNLIT;
        endcase
      end
    end
  end

  flame_anim_counter #(
    .FRAME_TICKS(FRAME_TICKS),
    .NUM_FRAMES (NUM_FRAMES)
  ) u_flame (
    .sim_clk(sim_clk),
    .reset  (reset),
    .en_i   (lit_q),
    .frame_o(frame)
  );

  // Renderer word, one tick behind the internal state; progress hidden once lit
  always_ff @(posedge sim_clk) begin
    if (reset) begin
      cs_q.x        <= CAMP_X;
      cs_q.y        <= CAMP_Y;
      cs_q.lit      <= 1'b0;
      cs_q.lighting <= 1'b0;
      cs_q.frame    <= '0;
      cs_q.progress <= '0;
    end else begin
      cs_q.x        <= CAMP_X;
      cs_q.y        <= CAMP_Y;
      cs_q.lit      <= lit_q;
      cs_q.lighting <= (state_q == ST_LIGHTING);
      cs_q.frame    <= frame;
      cs_q.progress <= lit_q ? '0 : progress_q;
    end
  end

  assign respawn_req    = req_q;
  assign respawn_x      = rx_q;
  assign respawn_y      = ry_q;
  assign checkpoint_set = cp_set_q;
  assign campfireState  = cs_q;

endmodule

// File: tb/tb_campfire_checkpoint_ctrl.sv
// Directed bench for the campfire checkpoint controller: an overlap table
// followed by hand-written lighting, abort, death and reset sequences.
module tb_campfire_checkpoint_ctrl;

  logic        sim_clk = 1'b0;
  logic        reset;
  logic [9:0]  player_x, player_y;
  logic        interact, player_dead, respawn_ack;
  logic        respawn_req;
  logic [9:0]  respawn_x, respawn_y;
  logic        checkpoint_set;
  logic [31:0] campfireState;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] CS_RST = {10'd250, 10'd180, 12'd0};

  typedef struct {
    logic [9:0] px;
    logic [9:0] py;
    logic       inter;
    logic       exp_light;
  } ovl_vec_t;

  ovl_vec_t ovl[13];

  campfire_checkpoint_ctrl dut (
    .sim_clk       (sim_clk),
    .reset         (reset),
    .player_x      (player_x),
    .player_y      (player_y),
    .interact      (interact),
    .player_dead   (player_dead),
    .respawn_ack   (respawn_ack),
    .respawn_req   (respawn_req),
    .respawn_x     (respawn_x),
    .respawn_y     (respawn_y),
    .checkpoint_set(checkpoint_set),
    .campfireState (campfireState)
  );

  always #5 sim_clk = ~sim_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge sim_clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    interact    = 1'b0;
    player_dead = 1'b0;
    respawn_ack = 1'b0;
    player_x    = 10'd0;
    player_y    = 10'd0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    ovl[0]  = '{10'd250,  10'd180,  1'b1, 1'b1};
    ovl[1]  = '{10'd234,  10'd180,  1'b1, 1'b0};
    ovl[2]  = '{10'd235,  10'd180,  1'b1, 1'b1};
    ovl[3]  = '{10'd265,  10'd180,  1'b1, 1'b1};
    ovl[4]  = '{10'd266,  10'd180,  1'b1, 1'b0};
    ovl[5]  = '{10'd250,  10'd164,  1'b1, 1'b0};
    ovl[6]  = '{10'd250,  10'd165,  1'b1, 1'b1};
    ovl[7]  = '{10'd250,  10'd195,  1'b1, 1'b1};
    ovl[8]  = '{10'd250,  10'd196,  1'b1, 1'b0};
    ovl[9]  = '{10'd0,    10'd0,    1'b1, 1'b0};
    ovl[10] = '{10'd1023, 10'd1023, 1'b1, 1'b0};
    ovl[11] = '{10'd1023, 10'd180,  1'b1, 1'b0};
    ovl[12] = '{10'd250,  10'd180,  1'b0, 1'b0};

    // Reset state
    do_reset();
    chk("rst_req", 32'(respawn_req), 32'd0);
    chk("rst_rx", 32'(respawn_x), 32'd20);
    chk("rst_ry", 32'(respawn_y), 32'd200);
    chk("rst_cpset", 32'(checkpoint_set), 32'd0);
    chk("rst_state_word", campfireState, CS_RST);

    // Overlap table: one tick to enter LIGHTING, one more to see it in the word
    for (int i = 0; i < 13; i++) begin
      do_reset();
      player_x = ovl[i].px;
      player_y = ovl[i].py;
      interact = ovl[i].inter;
      tick();
      tick();
      chk($sformatf("ovl%0d_lighting", i), 32'(campfireState[10]), 32'(ovl[i].exp_light));
      chk($sformatf("ovl%0d_progress", i), 32'(campfireState[7:0]), 32'(ovl[i].exp_light));
    end

    // 1: 30 held ticks light the campfire
    do_reset();
    player_x = 10'd250; player_y = 10'd180; interact = 1'b1;
    for (int t = 1; t <= 30; t++) begin
      tick();
      chk($sformatf("t1_cpset_tick%0d", t), 32'(checkpoint_set), 32'(t == 30));
    end
    chk("t1_lit_before", 32'(campfireState[11]), 32'd0);
    chk("t1_lighting_before", 32'(campfireState[10]), 32'd1);
    chk("t1_progress_29", 32'(campfireState[7:0]), 32'd29);
    tick();
    chk("t1_cpset_drop", 32'(checkpoint_set), 32'd0);
    chk("t1_lit_after", 32'(campfireState[11]), 32'd1);
    chk("t1_lighting_after", 32'(campfireState[10]), 32'd0);
    chk("t1_progress_hidden", 32'(campfireState[7:0]), 32'd0);
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("t1_cpset_once", 32'(checkpoint_set), 32'd0);
    end

    // 2: release after 10 ticks aborts; relighting needs a full 30
    do_reset();
    player_x = 10'd250; player_y = 10'd180; interact = 1'b1;
    for (int t = 0; t < 10; t++) tick();
    interact = 1'b0;
    tick();
    chk("t2_lighting_at_release", 32'(campfireState[10]), 32'd1);
    chk("t2_progress_10", 32'(campfireState[7:0]), 32'd10);
    tick();
    chk("t2_unlit", 32'(campfireState[10]), 32'd0);
    chk("t2_progress_cleared", 32'(campfireState[7:0]), 32'd0);
    interact = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 2) chk("t2_restart_progress", 32'(campfireState[7:0]), 32'd1);
      chk($sformatf("t2_cpset_tick%0d", k), 32'(checkpoint_set), 32'(k == 30));
    end

    // 3: edge-touching player never lights
    do_reset();
    player_x = 10'd234; player_y = 10'd180; interact = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      chk($sformatf("t3_lighting_tick%0d", t), 32'(campfireState[10]), 32'd0);
    end
    chk("t3_cpset", 32'(checkpoint_set), 32'd0);

    // 4: death while unlit, req held without ack, ack returns to UNLIT
    do_reset();
    respawn_ack = 1'b1;
    tick();
    respawn_ack = 1'b0;
    chk("t4_stray_ack", 32'(respawn_req), 32'd0);
    player_dead = 1'b1;
    tick();
    player_dead = 1'b0;
    chk("t4_req", 32'(respawn_req), 32'd1);
    chk("t4_rx", 32'(respawn_x), 32'd20);
    chk("t4_ry", 32'(respawn_y), 32'd200);
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("t4_req_held", 32'(respawn_req), 32'd1);
    end
    player_dead = 1'b1;
    tick();
    player_dead = 1'b0;
    chk("t4_dead_ignored_req", 32'(respawn_req), 32'd1);
    chk("t4_dead_ignored_rx", 32'(respawn_x), 32'd20);
    respawn_ack = 1'b1;
    tick();
    respawn_ack = 1'b0;
    chk("t4_req_drop", 32'(respawn_req), 32'd0);
    player_x = 10'd250; player_y = 10'd180; interact = 1'b1;
    tick();
    tick();
    chk("t4_back_unlit_lighting", 32'(campfireState[10]), 32'd1);
    chk("t4_back_unlit_progress", 32'(campfireState[7:0]), 32'd1);

    // 5: death after lit; flame keeps cycling through RESPAWN; ack returns to LIT
    do_reset();
    player_x = 10'd250; player_y = 10'd180; interact = 1'b1;
    for (int e = 1; e <= 30; e++) tick();
    for (int e = 31; e <= 72; e++) begin
      player_dead = (e == 33 || e == 50);
      tick();
      chk($sformatf("t5_frame_tick%0d", e), 32'(campfireState[9:8]), 32'(((e - 31) / 8) % 4));
      if (e == 33) begin
        chk("t5_req", 32'(respawn_req), 32'd1);
        chk("t5_rx", 32'(respawn_x), 32'd250);
        chk("t5_ry", 32'(respawn_y), 32'd164);
      end
      if (e == 40) chk("t5_lit_kept", 32'(campfireState[11]), 32'd1);
      if (e == 50) begin
        chk("t5_dead_ignored_req", 32'(respawn_req), 32'd1);
        chk("t5_dead_ignored_ry", 32'(respawn_y), 32'd164);
      end
    end
    player_dead = 1'b0;
    respawn_ack = 1'b1;
    tick();
    respawn_ack = 1'b0;
    chk("t5_req_drop", 32'(respawn_req), 32'd0);
    tick();
    chk("t5_lit_after_ack", 32'(campfireState[11]), 32'd1);
    chk("t5_cpset_after_ack", 32'(checkpoint_set), 32'd0);
    tick();
    chk("t5_not_relighting", 32'(campfireState[10]), 32'd0);
    player_dead = 1'b1;
    tick();
    player_dead = 1'b0;
    chk("t5_req2", 32'(respawn_req), 32'd1);
    chk("t5_rx2", 32'(respawn_x), 32'd250);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_rst_req", 32'(respawn_req), 32'd0);
    chk("t5_rst_rx", 32'(respawn_x), 32'd20);
    chk("t5_rst_ry", 32'(respawn_y), 32'd200);
    chk("t5_rst_word", campfireState, CS_RST);
    chk("t5_rst_cpset", 32'(checkpoint_set), 32'd0);

    // 6: death on the completing tick beats lighting; reset while req is high
    do_reset();
    player_x = 10'd250; player_y = 10'd180; interact = 1'b1;
    for (int t = 0; t < 29; t++) tick();
    player_dead = 1'b1;
    tick();
    player_dead = 1'b0;
    chk("t6_no_cpset", 32'(checkpoint_set), 32'd0);
    chk("t6_req", 32'(respawn_req), 32'd1);
    chk("t6_rx", 32'(respawn_x), 32'd20);
    chk("t6_ry", 32'(respawn_y), 32'd200);
    tick();
    chk("t6_not_lit", 32'(campfireState[11]), 32'd0);
    chk("t6_not_lighting", 32'(campfireState[10]), 32'd0);
    chk("t6_cpset_still_low", 32'(checkpoint_set), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rst_req", 32'(respawn_req), 32'd0);
    chk("t6_rst_word", campfireState, CS_RST);
    chk("t6_rst_rx", 32'(respawn_x), 32'd20);
    chk("t6_rst_ry", 32'(respawn_y), 32'd200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
